// File: rtl/uart_pkg.sv
// Shared UART transmitter types: FSM state encoding, parity selections and latched frame config.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef struct packed {
    logic [1:0] parity_mode;
    logic       two_stop;
  } frame_cfg_t;

  // Mode 3 is reserved and behaves as no parity.
  function automatic logic has_parity(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..end_val and wraps; tc is high for the cycle count==end_val.
// Zero latency on tc; clr has priority and forces the count back to 0 on the next edge.
module uart_bit_timer #(
  parameter int div_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [div_width-1:0] end_val,
  output logic                 tc
);

  logic [div_width-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || tc) begin
      count <= '0;
    end else begin
      count <= count + div_width'(1);
    end
  end

  assign tc = (count == end_val);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with runtime parity/stop/baud config and a one-word holding buffer.
// Start bit leaves one cycle after the buffer fills; tx_ready drops while the buffer holds a word.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int data_size = 8,
  parameter int div_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [data_size-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [div_width-1:0] baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic                 tx_s,
  output logic                 busy
);

  localparam int CW = $clog2(data_size);
  localparam logic [CW-1:0] LAST_BIT = CW'(data_size - 1);

  logic [data_size-1:0] buf_dat;
  logic                 buf_vld;
  logic [data_size-1:0] shifter;
  logic                 par_bit;
  logic [div_width-1:0] div_q;
  frame_cfg_t           cfg_q;
  state_t               state;
  logic [CW-1:0]        bit_cnt;
  logic                 stop_second;
  logic                 tc;
  logic                 load;

  // A frame is loaded from idle, or straight off the final stop bit for gapless back-to-back.
  assign load = buf_vld &&
                ((state == ST_IDLE) ||
                 ((state == ST_STOP) && tc && (!cfg_q.two_stop || stop_second)));

  uart_bit_timer #(
    .div_width(div_width)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (load || (state == ST_IDLE)),
    .end_val(div_q),
    .tc     (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_dat  <= '0;
      buf_vld  <= 1'b0;
      tx_ready <= 1'b1;
    end else if (load) begin
      buf_vld  <= 1'b0;
      tx_ready <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      buf_dat  <= tx_data;
      buf_vld  <= 1'b1;
      tx_ready <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      tx_s        <= 1'b1;
      busy        <= 1'b0;
      shifter     <= '0;
      par_bit     <= 1'b0;
      div_q       <= '0;
      cfg_q       <= '0;
      bit_cnt     <= '0;
      stop_second <= 1'b0;
    end else if (load) begin
      shifter           <= buf_dat;
      par_bit           <= (parity_mode == PAR_ODD) ? ~^buf_dat : ^buf_dat;
      div_q             <= baud_div;
      cfg_q.parity_mode <= parity_mode;
      cfg_q.two_stop    <= two_stop;
      bit_cnt           <= '0;
      stop_second       <= 1'b0;
      state             <= ST_START;
      tx_s              <= 1'b0;
      busy              <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_s <= 1'b1;
          busy <= 1'b0;
        end
        ST_START: begin
          if (tc) begin
            state   <= ST_DATA;
            tx_s    <= shifter[0];
            shifter <= shifter >> 1;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (tc) begin
            if (bit_cnt == LAST_BIT) begin
              if (has_parity(cfg_q.parity_mode)) begin
                state <= ST_PARITY;
                tx_s  <= par_bit;
              end else begin
                state <= ST_STOP;
                tx_s  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
              tx_s    <= shifter[0];
              shifter <= shifter >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (tc) begin
            state <= ST_STOP;
            tx_s  <= 1'b1;
          end
        end
        ST_STOP: begin
          if (tc) begin
            if (cfg_q.two_stop && !stop_second) begin
              stop_second <= 1'b1;
            end else begin
              state <= ST_IDLE;
              tx_s  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx_s  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
